hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage xgriscv datapath.
- Detects RAW hazards and generates the EX-stage and ID-stage (branch compare) forwarding selects.
- Generates stall and flush signals for load-use hazards, decode-stage branch dependencies and taken-branch redirects.
- Sequences an iterative multi-cycle mul/div unit in EX through a start/done handshake. Keeps saturating stall and flush counters.

Parameters:
- RFIDX_WIDTH, 5, register index width
- CNT_WIDTH, 32, width of the performance counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rs1D, rs2D  in  RFIDX_WIDTH  source registers of the instruction in ID
- users1D, users2D  in  1  the ID instruction reads rs1 / rs2
- branchD  in  1  the ID instruction compares or uses operands in ID (branch, jalr)
- pcsrcD  in  1  redirect request from ID
- rs1E, rs2E, rdE  in  RFIDX_WIDTH  EX register indices
- regwriteE, memtoregE, mdE  in  1  EX control: writes rd, is a load, is a mul/div
- rdM  in  RFIDX_WIDTH  MEM destination register
- regwriteM, memtoregM  in  1  MEM control: writes rd, is a load
- rdW  in  RFIDX_WIDTH  WB destination register
- regwriteW  in  1  WB control: writes rd
- md_done  in  1  one-cycle pulse from the mul/div unit
- stallF, stallD, stallE  out  1  hold the PC / IF-ID / ID-EX registers
- flushD, flushE, flushM  out  1  clear the IF-ID / ID-EX / EX-MEM registers
- forwardaE, forwardbE  out  2  00 = register file, 01 = wdataW, 10 = aluoutM
- forwardaD, forwardbD  out  2  same encoding, for the ID comparator
- pcsrc_enD  out  1  redirect qualifier, equal to ~stallD
- md_start  out  1  registered one-cycle start pulse to the mul/div unit
- md_busy  out  1  FSM is not in IDLE
- stall_cnt, flush_cnt  out  CNT_WIDTH  saturating performance counters

Behaviour:
- Reset: FSM goes to IDLE; md_start=0; md_busy=0; both counters=0. All other outputs are combinational from the inputs and the FSM state.
- match(r, rd): r == rd and rd != 0. A destination of x0 never forwards and never stalls.
- forwardaE: 10 if regwriteM & match(rs1E, rdM); else 01 if regwriteW & match(rs1E, rdW); else 00. MEM has priority over WB. forwardbE is the same using rs2E.
- forwardaD / forwardbD: same rule applied to rs1D / rs2D, with the MEM case additionally requiring ~memtoregM.
- loaduse: memtoregE & ((users1D & match(rs1D, rdE)) | (users2D & match(rs2D, rdE))).
- brstall: branchD & (regwriteE & match(rsXD, rdE) for either used source, | memtoregM & match(rsXD, rdM) for either used source).
- Hazard stall (loaduse | brstall), when no md stall is active: stallF=stallD=1, flushE=1 (bubble), stallE=0.
- flushD = pcsrcD & ~stallD.
- FSM, states IDLE, BUSY, COMPLETE:
  - IDLE, mdE=1: register md_start=1 for the next cycle only, go to BUSY. md stall is asserted in this cycle.
  - BUSY: md stall asserted; md_done=1 moves to COMPLETE.
  - COMPLETE: no md stall; EX advances with the result; always returns to IDLE. mdE is still high in this cycle and must not restart the unit.
- md stall: stallF=stallD=stallE=1, flushM=1, flushE=0, flushD=0. It overrides the hazard stall and any redirect.
- md_done outside BUSY is ignored.
- md_busy = (state != IDLE).
- Back-to-back mul/div instructions: IDLE is entered for one cycle between them, and the next instruction issues from IDLE.
- Counters:
  - stall_cnt increments on every cycle with stallF=1; flush_cnt increments on every cycle with flushD=1.
  - Both saturate at all-ones.
- Asynchronous reset during BUSY: FSM returns to IDLE immediately, no further md_start is issued, and a later md_done is ignored.

Decomposition:
- Shared package / xgriscv_defines.v:
  - forwarding encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - FSM state encodings
  - CNT_WIDTH default
- One sub-module, md_seq: the 3-state FSM plus the md_start register, producing md_stall and md_busy.
- The forwarding and hazard logic stay in the top module.

Test Plan:
1. RAW forwarding:
   - rdM=5 with regwriteM=1 and rs1E=5 -> forwardaE=10.
   - Producer only in WB (rdW=5, regwriteW=1) -> forwardaE=01.
   - rdM=0 with rs1E=0 -> forwardaE=00.
2. Load-use: memtoregE=1, rdE=6, rs2D=6, users2D=1 -> stallF=stallD=flushE=1 for exactly one cycle; stall_cnt becomes 1.
3. Branch on a load:
   - branchD=1, rs1D=7, load to x7 in EX -> stall for 2 cycles.
   - Third cycle: forwardaD=01, and pcsrcD=1 -> flushD=1, flush_cnt=1.
4. Mul/div:
   - mdE=1 -> md_start high for exactly one cycle; md_busy=1.
   - md_done arrives 8 cycles after issue -> COMPLETE with no stall and no second md_start; stall_cnt=9.
5. Reset mid-BUSY:
   - Assert reset 3 cycles into BUSY -> md_busy=0 and counters=0 immediately.
   - md_done pulse 2 cycles later -> no state change.
6. Simultaneous events: during BUSY, apply pcsrcD=1 with a loaduse condition -> flushD=0, flushE=0, pcsrc_enD=0, flushM=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the xgriscv pipeline hazard controller
//
// Contents:
//   FWD_RF / FWD_W / FWD_M  forwarding mux selects (register file, WB data, MEM alu result)
//   mdState_e               mul/div sequencer states
//   CNT_WIDTH_DEF           default performance counter width
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int CNT_WIDTH_DEF   = 32;
    localparam int RFIDX_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        MD_IDLE     = 2'b00,
        MD_BUSY     = 2'b01,
        MD_COMPLETE = 2'b10
    } mdState_e;

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// rtl/hazard_ctrl_md_seq.sv - start/done sequencer for the iterative mul/div unit in EX
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   mdE         a mul/div instruction sits in EX
//   md_done     one-cycle completion pulse from the unit (only honoured in BUSY)
//   md_start    registered one-cycle start pulse
//   md_stall    freeze the front of the pipeline while the unit works
//   md_busy     sequencer is not idle
module hazard_ctrl_md_seq
    import hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic mdE,
    input  logic md_done,
    output logic md_start,
    output logic md_stall,
    output logic md_busy
);

    mdState_e state;
    mdState_e nextState;
    logic     startNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MD_IDLE;
            md_start <= 1'b0;
        end else begin
            state    <= nextState;
            md_start <= startNext;
        end
    end

    // COMPLETE lets the finished instruction leave EX; mdE is still high
    // there, so only IDLE may launch the unit.
    always_comb begin
        nextState = state;
        startNext = 1'b0;
        md_stall  = 1'b0;
        case (state)
            MD_IDLE: begin
                if (mdE) begin
                    nextState = MD_BUSY;
                    startNext = 1'b1;
                    md_stall  = 1'b1;
                end
            end
            MD_BUSY: begin
                md_stall = 1'b1;
                if (md_done) begin
                    nextState = MD_COMPLETE;
                end
            end
            MD_COMPLETE: begin
                nextState = MD_IDLE;
            end
            default: begin
                nextState = MD_IDLE;
            end
        endcase
    end

    assign md_busy = (state != MD_IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall/flush generation and mul/div sequencing for the 5-stage xgriscv pipeline
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   rs1D, rs2D, users1D, users2D     ID sources and whether they are read
//   branchD, pcsrcD                  ID uses operands in its comparator / requests a redirect
//   rs1E, rs2E, rdE                  EX register indices
//   regwriteE, memtoregE, mdE        EX writes rd / is a load / is a mul/div
//   rdM, regwriteM, memtoregM        MEM destination, writes rd / is a load
//   rdW, regwriteW                   WB destination, writes rd
//   md_done                          completion pulse from the mul/div unit
//   stallF, stallD, stallE           hold PC / IF-ID / ID-EX
//   flushD, flushE, flushM           clear IF-ID / ID-EX / EX-MEM
//   forwardaE, forwardbE             EX operand selects
//   forwardaD, forwardbD             ID comparator operand selects
//   pcsrc_enD                        redirect qualifier
//   md_start, md_busy                mul/div start pulse, sequencer active
//   stall_cnt, flush_cnt             saturating stall / redirect counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RFIDX_WIDTH = RFIDX_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RFIDX_WIDTH-1:0] rs1D,
    input  logic [RFIDX_WIDTH-1:0] rs2D,
    input  logic                   users1D,
    input  logic                   users2D,
    input  logic                   branchD,
    input  logic                   pcsrcD,
    input  logic [RFIDX_WIDTH-1:0] rs1E,
    input  logic [RFIDX_WIDTH-1:0] rs2E,
    input  logic [RFIDX_WIDTH-1:0] rdE,
    input  logic                   regwriteE,
    input  logic                   memtoregE,
    input  logic                   mdE,
    input  logic [RFIDX_WIDTH-1:0] rdM,
    input  logic                   regwriteM,
    input  logic                   memtoregM,
    input  logic [RFIDX_WIDTH-1:0] rdW,
    input  logic                   regwriteW,
    input  logic                   md_done,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   flushM,
    output logic [1:0]             forwardaE,
    output logic [1:0]             forwardbE,
    output logic [1:0]             forwardaD,
    output logic [1:0]             forwardbD,
    output logic                   pcsrc_enD,
    output logic                   md_start,
    output logic                   md_busy,
    output logic [CNT_WIDTH-1:0]   stall_cnt,
    output logic [CNT_WIDTH-1:0]   flush_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic mdStall;
    logic loadUse;
    logic brStall;
    logic hazStall;

    // x0 is hardwired to zero, so a write to it is never a real producer.
    function automatic logic regMatch(input logic [RFIDX_WIDTH-1:0] r,
                                      input logic [RFIDX_WIDTH-1:0] rd);
        return (r == rd) && (rd != '0);
    endfunction

    // MEM has priority over WB because it holds the younger value.
    function automatic logic [1:0] fwdSel(input logic [RFIDX_WIDTH-1:0] r,
                                          input logic                   mValid,
                                          input logic [RFIDX_WIDTH-1:0] mRd,
                                          input logic                   wValid,
                                          input logic [RFIDX_WIDTH-1:0] wRd);
        if (mValid && regMatch(r, mRd)) begin
            return FWD_M;
        end else if (wValid && regMatch(r, wRd)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    hazard_ctrl_md_seq u_md_seq (
        .clk      (clk),
        .reset    (reset),
        .mdE      (mdE),
        .md_done  (md_done),
        .md_start (md_start),
        .md_stall (mdStall),
        .md_busy  (md_busy)
    );

    // The ID comparator cannot take load data from MEM (it is not ready
    // until WB), so a MEM load is excluded from ID forwarding.
    always_comb begin
        forwardaE = fwdSel(rs1E, regwriteM, rdM, regwriteW, rdW);
        forwardbE = fwdSel(rs2E, regwriteM, rdM, regwriteW, rdW);
        forwardaD = fwdSel(rs1D, regwriteM & ~memtoregM, rdM, regwriteW, rdW);
        forwardbD = fwdSel(rs2D, regwriteM & ~memtoregM, rdM, regwriteW, rdW);
    end

    always_comb begin
        loadUse = memtoregE &
                  ((users1D & regMatch(rs1D, rdE)) |
                   (users2D & regMatch(rs2D, rdE)));

        // A branch needs its operands in ID: any EX producer is too late,
        // and a MEM load is too late as well.
        brStall = branchD &
                  ((users1D & ((regwriteE & regMatch(rs1D, rdE)) |
                               (memtoregM & regMatch(rs1D, rdM)))) |
                   (users2D & ((regwriteE & regMatch(rs2D, rdE)) |
                               (memtoregM & regMatch(rs2D, rdM)))));

        hazStall = loadUse | brStall;
    end

    // The mul/div freeze holds everything up to EX and drains MEM with a
    // bubble; it dominates the decode hazard and any redirect.
    always_comb begin
        stallF    = mdStall | hazStall;
        stallD    = mdStall | hazStall;
        stallE    = mdStall;
        flushE    = hazStall & ~mdStall;
        flushM    = mdStall;
        pcsrc_enD = ~stallD;
        flushD    = pcsrcD & ~stallD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallF && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flushD && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam logic [5:0] F_NONE = 6'b000000; // {stallF,stallD,stallE,flushD,flushE,flushM}
    localparam logic [5:0] F_HAZ  = 6'b110010;
    localparam logic [5:0] F_MD   = 6'b111001;
    localparam logic [5:0] F_RDR  = 6'b000100;

    typedef struct {
        string       name;
        logic [16:0] vec;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       users1D, users2D, branchD, pcsrcD;
    logic       regwriteE, memtoregE, mdE, regwriteM, memtoregM, regwriteW, md_done;

    logic        stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0]  forwardaE, forwardbE, forwardaD, forwardbD;
    logic        pcsrc_enD, md_start, md_busy;
    logic [31:0] stall_cnt, flush_cnt;

    logic        sStallF, sStallD, sStallE, sFlushD, sFlushE, sFlushM;
    logic [1:0]  sFaE, sFbE, sFaD, sFbD;
    logic        sPcen, sMdStart, sMdBusy;
    logic [3:0]  sStallCnt, sFlushCnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .users1D(users1D), .users2D(users2D),
        .branchD(branchD), .pcsrcD(pcsrcD),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .mdE(mdE),
        .rdM(rdM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .rdW(rdW), .regwriteW(regwriteW), .md_done(md_done),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .pcsrc_enD(pcsrc_enD), .md_start(md_start), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_WIDTH(4)) satDut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .users1D(users1D), .users2D(users2D),
        .branchD(branchD), .pcsrcD(pcsrcD),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .mdE(mdE),
        .rdM(rdM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .rdW(rdW), .regwriteW(regwriteW), .md_done(md_done),
        .stallF(sStallF), .stallD(sStallD), .stallE(sStallE),
        .flushD(sFlushD), .flushE(sFlushE), .flushM(sFlushM),
        .forwardaE(sFaE), .forwardbE(sFbE),
        .forwardaD(sFaD), .forwardbD(sFbD),
        .pcsrc_enD(sPcen), .md_start(sMdStart), .md_busy(sMdBusy),
        .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
    );

    function automatic logic [16:0] mk(input logic [5:0] f, input logic [1:0] aE, input logic [1:0] bE,
                                       input logic [1:0] aD, input logic [1:0] bD,
                                       input logic pen, input logic ms, input logic mb);
        return {f, aE, bE, aD, bD, pen, ms, mb};
    endfunction

    function automatic logic [16:0] actVec();
        return {stallF, stallD, stallE, flushD, flushE, flushM,
                forwardaE, forwardbE, forwardaD, forwardbD, pcsrc_enD, md_start, md_busy};
    endfunction

    function automatic exp_t mkExp(input string n, input logic [16:0] v, input int sc, input int fc);
        exp_t e;
        e.name = n;
        e.vec  = v;
        e.sc   = sc;
        e.fc   = fc;
        return e;
    endfunction

    task automatic clearInputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        users1D = 0; users2D = 0; branchD = 0; pcsrcD = 0;
        regwriteE = 0; memtoregE = 0; mdE = 0;
        regwriteM = 0; memtoregM = 0; regwriteW = 0; md_done = 0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        clearInputs();
        @(negedge clk);
        expQ.push_back(mkExp("reset", mk(F_NONE, 0, 0, 0, 0, 1, 0, 0), 0, 0));
        #1;
        e = expQ.pop_front();
        checks++; if (actVec() !== e.vec) begin errors++; $display("FAIL %s outputs: got %b required %b", e.name, actVec(), e.vec); end
        checks++; if (stall_cnt !== e.sc) begin errors++; $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.sc); end
        checks++; if (flush_cnt !== e.fc) begin errors++; $display("FAIL %s flush_cnt: got %0d required %0d", e.name, flush_cnt, e.fc); end
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        exp_t e;
        logic [16:0] v;
        applyReset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clearInputs();
            case (i)
                0: begin rs1E = 5; rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1; v = mk(F_NONE, 2'b10, 0, 0, 0, 1, 0, 0); end
                1: begin rs1E = 5; rdW = 5; regwriteW = 1; v = mk(F_NONE, 2'b01, 0, 0, 0, 1, 0, 0); end
                2: begin rs1E = 0; rdM = 0; regwriteM = 1; rdW = 0; regwriteW = 1; v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0); end
                3: begin rs2E = 9; rs2D = 9; rs1D = 3; rdM = 9; regwriteM = 1; memtoregM = 1; rdW = 9; regwriteW = 1;
                         v = mk(F_NONE, 0, 2'b10, 0, 2'b01, 1, 0, 0); end
                4: begin rs1D = 4; rs2E = 4; rdM = 4; regwriteM = 1; v = mk(F_NONE, 0, 2'b10, 2'b10, 0, 1, 0, 0); end
                default: begin rs1E = 5; rdM = 5; rdW = 5; v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0); end
            endcase
            expQ.push_back(mkExp($sformatf("fwd%0d", i), v, 0, 0));
            #1;
            e = expQ.pop_front();
            checks++; if (actVec() !== e.vec) begin errors++; $display("FAIL %s outputs: got %b required %b", e.name, actVec(), e.vec); end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [16:0] v;
        int sc;
        applyReset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clearInputs();
            sc = (i >= 3) ? 1 : 0;
            case (i)
                0: begin memtoregE = 1; regwriteE = 1; rdE = 6; rs2D = 6; users2D = 0; v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0); end
                1: begin memtoregE = 1; regwriteE = 1; rdE = 0; rs1D = 0; users1D = 1; v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0); end
                2: begin memtoregE = 1; regwriteE = 1; rdE = 6; rs2D = 6; users2D = 1; v = mk(F_HAZ, 0, 0, 0, 0, 0, 0, 0); end
                3: begin memtoregM = 1; regwriteM = 1; rdM = 6; rs2D = 6; users2D = 1; v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0); end
                default: begin v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0); end
            endcase
            expQ.push_back(mkExp($sformatf("loaduse%0d", i), v, sc, 0));
            #1;
            e = expQ.pop_front();
            checks++; if (actVec() !== e.vec) begin errors++; $display("FAIL %s outputs: got %b required %b", e.name, actVec(), e.vec); end
            checks++; if (stall_cnt !== e.sc) begin errors++; $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.sc); end
        end
    endtask

    task automatic test_branch_load();
        exp_t e;
        logic [16:0] v;
        int sc, fc;
        applyReset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clearInputs();
            case (i)
                0: begin branchD = 1; users1D = 1; rs1D = 7; memtoregE = 1; regwriteE = 1; rdE = 7;
                         v = mk(F_HAZ, 0, 0, 0, 0, 0, 0, 0); sc = 0; fc = 0; end
                1: begin branchD = 1; users1D = 1; rs1D = 7; memtoregM = 1; regwriteM = 1; rdM = 7;
                         v = mk(F_HAZ, 0, 0, 0, 0, 0, 0, 0); sc = 1; fc = 0; end
                2: begin branchD = 1; users1D = 1; rs1D = 7; regwriteW = 1; rdW = 7; pcsrcD = 1;
                         v = mk(F_RDR, 0, 0, 2'b01, 0, 1, 0, 0); sc = 2; fc = 0; end
                3: begin branchD = 1; users2D = 1; rs2D = 8; regwriteE = 1; rdE = 8; pcsrcD = 1;
                         v = mk(F_HAZ, 0, 0, 0, 0, 0, 0, 0); sc = 2; fc = 1; end
                4: begin branchD = 1; users2D = 1; rs2D = 8; regwriteM = 1; rdM = 8;
                         v = mk(F_NONE, 0, 0, 0, 2'b10, 1, 0, 0); sc = 3; fc = 1; end
                default: begin v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0); sc = 3; fc = 1; end
            endcase
            expQ.push_back(mkExp($sformatf("branch%0d", i), v, sc, fc));
            #1;
            e = expQ.pop_front();
            checks++; if (actVec() !== e.vec) begin errors++; $display("FAIL %s outputs: got %b required %b", e.name, actVec(), e.vec); end
            checks++; if (stall_cnt !== e.sc) begin errors++; $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.sc); end
            checks++; if (flush_cnt !== e.fc) begin errors++; $display("FAIL %s flush_cnt: got %0d required %0d", e.name, flush_cnt, e.fc); end
        end
    endtask

    task automatic test_muldiv();
        exp_t e;
        logic [16:0] v;
        applyReset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            clearInputs();
            mdE     = (i <= 9);
            md_done = (i == 8);
            if (i == 0)      v = mk(F_MD, 0, 0, 0, 0, 0, 0, 0);
            else if (i <= 8) v = mk(F_MD, 0, 0, 0, 0, 0, (i == 1), 1);
            else if (i == 9) v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 1);
            else             v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0);
            expQ.push_back(mkExp($sformatf("muldiv%0d", i), v, (i <= 9) ? i : 9, 0));
            #1;
            e = expQ.pop_front();
            checks++; if (actVec() !== e.vec) begin errors++; $display("FAIL %s outputs: got %b required %b", e.name, actVec(), e.vec); end
            checks++; if (stall_cnt !== e.sc) begin errors++; $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.sc); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [16:0] v;
        int sc;
        applyReset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            clearInputs();
            mdE     = (i <= 5);
            md_done = (i == 1) || (i == 4) || (i == 7);
            case (i)
                0: begin v = mk(F_MD, 0, 0, 0, 0, 0, 0, 0);   sc = 0; end
                1: begin v = mk(F_MD, 0, 0, 0, 0, 0, 1, 1);   sc = 1; end
                2: begin v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 1); sc = 2; end
                3: begin v = mk(F_MD, 0, 0, 0, 0, 0, 0, 0);   sc = 2; end
                4: begin v = mk(F_MD, 0, 0, 0, 0, 0, 1, 1);   sc = 3; end
                5: begin v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 1); sc = 4; end
                default: begin v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0); sc = 4; end
            endcase
            expQ.push_back(mkExp($sformatf("b2b%0d", i), v, sc, 0));
            #1;
            e = expQ.pop_front();
            checks++; if (actVec() !== e.vec) begin errors++; $display("FAIL %s outputs: got %b required %b", e.name, actVec(), e.vec); end
            checks++; if (stall_cnt !== e.sc) begin errors++; $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.sc); end
        end
    endtask

    task automatic test_reset_mid_busy();
        exp_t e;
        logic [16:0] v;
        applyReset();
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                // asynchronous reset in the middle of the cycle, third BUSY cycle
                #2;
                mdE   = 0;
                reset = 1'b1;
            end else begin
                @(negedge clk);
                if (i == 5) reset = 1'b0;
                clearInputs();
                mdE     = (i <= 3);
                md_done = (i == 7);
            end
            if (i == 0)      v = mk(F_MD, 0, 0, 0, 0, 0, 0, 0);
            else if (i <= 3) v = mk(F_MD, 0, 0, 0, 0, 0, (i == 1), 1);
            else             v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0);
            expQ.push_back(mkExp($sformatf("rstbusy%0d", i), v, (i <= 3) ? i : 0, 0));
            #1;
            e = expQ.pop_front();
            checks++; if (actVec() !== e.vec) begin errors++; $display("FAIL %s outputs: got %b required %b", e.name, actVec(), e.vec); end
            checks++; if (stall_cnt !== e.sc) begin errors++; $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.sc); end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        logic [16:0] v;
        applyReset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clearInputs();
            mdE = (i <= 3);
            if (i >= 1 && i <= 3) begin
                pcsrcD = 1; memtoregE = 1; regwriteE = 1; rdE = 6; rs2D = 6; users2D = 1;
            end
            md_done = (i == 2);
            case (i)
                0: v = mk(F_MD, 0, 0, 0, 0, 0, 0, 0);
                1: v = mk(F_MD, 0, 0, 0, 0, 0, 1, 1);
                2: v = mk(F_MD, 0, 0, 0, 0, 0, 0, 1);
                3: v = mk(F_HAZ, 0, 0, 0, 0, 0, 0, 1);
                default: v = mk(F_NONE, 0, 0, 0, 0, 1, 0, 0);
            endcase
            expQ.push_back(mkExp($sformatf("simul%0d", i), v, i, 0));
            #1;
            e = expQ.pop_front();
            checks++; if (actVec() !== e.vec) begin errors++; $display("FAIL %s outputs: got %b required %b", e.name, actVec(), e.vec); end
            checks++; if (stall_cnt !== e.sc) begin errors++; $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.sc); end
            checks++; if (flush_cnt !== e.fc) begin errors++; $display("FAIL %s flush_cnt: got %0d required %0d", e.name, flush_cnt, e.fc); end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        applyReset();
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            clearInputs();
            if (i < 17) begin
                memtoregE = 1; regwriteE = 1; rdE = 3; rs1D = 3; users1D = 1;
            end else if (i < 33) begin
                pcsrcD = 1;
            end
            if (i == 14 || i == 16 || i == 17 || i == 33) begin
                // sc/fc hold the 4-bit instance expectations; main counter expectations follow in the name
                e.name = $sformatf("sat%0d", i);
                e.sc   = (i < 15) ? i : 15;
                e.fc   = (i <= 17) ? 0 : ((i - 17 < 15) ? i - 17 : 15);
                e.vec  = '0;
                expQ.push_back(e);
                #1;
                e = expQ.pop_front();
                checks++; if (sStallCnt !== e.sc[3:0]) begin errors++; $display("FAIL %s sat stall_cnt: got %0d required %0d", e.name, sStallCnt, e.sc); end
                checks++; if (sFlushCnt !== e.fc[3:0]) begin errors++; $display("FAIL %s sat flush_cnt: got %0d required %0d", e.name, sFlushCnt, e.fc); end
                checks++; if (stall_cnt !== ((i < 17) ? i : 17)) begin errors++; $display("FAIL %s wide stall_cnt: got %0d required %0d", e.name, stall_cnt, (i < 17) ? i : 17); end
                checks++; if (flush_cnt !== ((i <= 17) ? 0 : i - 17)) begin errors++; $display("FAIL %s wide flush_cnt: got %0d required %0d", e.name, flush_cnt, (i <= 17) ? 0 : i - 17); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        clearInputs();
        reset = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_load();
        test_muldiv();
        test_back_to_back();
        test_reset_mid_busy();
        test_simultaneous();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
